// File: rtl/reset_sequencer.sv
// Sequenced release of num_stages reset domains, each gated on its ack plus a gap.
// Define RESET_SEQUENCER_TIMEOUT_EN to enable the ack timeout and sticky FAULT state.
module reset_sequencer #(
    parameter int num_stages     = 4,
    parameter int hold_cycles    = 16,
    parameter int gap_cycles     = 8,
    parameter int timeout_cycles = 1024
) (
    input  logic                                                  clk,
    input  logic                                                  reset,
    input  logic [num_stages-1:0]                                 ack,
    output logic [num_stages-1:0]                                 rst_out,
    output logic [(num_stages > 1 ? $clog2(num_stages) : 1)-1:0]  stage_idx,
    output logic                                                  done,
    output logic                                                  fault
);

    localparam int SW     = (num_stages > 1) ? $clog2(num_stages) : 1;
    localparam int MAX_HG = (hold_cycles > gap_cycles) ? hold_cycles : gap_cycles;
    localparam int MAX_C  = (MAX_HG > timeout_cycles) ? MAX_HG : timeout_cycles;
    localparam int CW     = $clog2(MAX_C + 1);

    localparam logic [SW-1:0] LAST_IDX = SW'(num_stages - 1);
    localparam logic [CW-1:0] HOLD_END = CW'(hold_cycles - 1);
    localparam logic [CW-1:0] GAP_END  = CW'(gap_cycles - 1);

    localparam logic [2:0] S_HOLD    = 3'd0;
    localparam logic [2:0] S_RELEASE = 3'd1;
    localparam logic [2:0] S_WAIT    = 3'd2;
    localparam logic [2:0] S_GAP     = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;
`ifdef RESET_SEQUENCER_TIMEOUT_EN
    localparam logic [2:0] S_FAULT   = 3'd5;
    localparam logic [CW-1:0] TMO_END = CW'(timeout_cycles - 1);
`endif

    logic [2:0]            state, state_n;
    logic [CW-1:0]         cnt, cnt_n;
    logic [SW-1:0]         idx_n;
    logic [num_stages-1:0] rst_n;
    logic                  done_n;
`ifdef RESET_SEQUENCER_TIMEOUT_EN
    logic                  fault_r, fault_n;
`endif

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = stage_idx;
        rst_n   = rst_out;
        done_n  = done;
`ifdef RESET_SEQUENCER_TIMEOUT_EN
        fault_n = fault_r;
`endif
        case (state)
            S_HOLD: begin
                if (cnt == HOLD_END) begin
                    state_n = S_RELEASE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            S_RELEASE: begin
                rst_n[stage_idx] = 1'b0;
                state_n          = S_WAIT;
                cnt_n            = '0;
            end
            S_WAIT: begin
                // An ack seen on the timeout cycle still counts as progress.
                if (ack[stage_idx]) begin
                    cnt_n = '0;
                    if (stage_idx == LAST_IDX) begin
                        state_n = S_DONE;
                        done_n  = 1'b1;
                        rst_n   = '0;
                    end else begin
                        idx_n   = stage_idx + 1'b1;
                        state_n = (gap_cycles > 0) ? S_GAP : S_RELEASE;
                    end
                end
`ifdef RESET_SEQUENCER_TIMEOUT_EN
                else if (cnt == TMO_END) begin
                    state_n = S_FAULT;
                    fault_n = 1'b1;
                    rst_n   = '1;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
`endif
            end
            S_GAP: begin
                if (cnt == GAP_END) begin
                    state_n = S_RELEASE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            S_DONE: begin
                state_n = S_DONE;
            end
`ifdef RESET_SEQUENCER_TIMEOUT_EN
            S_FAULT: begin
                state_n = S_FAULT;
            end
`endif
            default: begin
                state_n = S_HOLD;
                cnt_n   = '0;
                idx_n   = '0;
                rst_n   = '1;
                done_n  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_HOLD;
            cnt       <= '0;
            stage_idx <= '0;
            rst_out   <= '1;
            done      <= 1'b0;
`ifdef RESET_SEQUENCER_TIMEOUT_EN
            fault_r   <= 1'b0;
`endif
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            stage_idx <= idx_n;
            rst_out   <= rst_n;
            done      <= done_n;
`ifdef RESET_SEQUENCER_TIMEOUT_EN
            fault_r   <= fault_n;
`endif
        end
    end

`ifdef RESET_SEQUENCER_TIMEOUT_EN
    assign fault = fault_r;
`else
    assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: default timing, slow ack, zero gap, mid-run reset,
// and (with RESET_SEQUENCER_TIMEOUT_EN) timeout fault and ack-on-timeout-cycle.
module tb_reset_sequencer;

    logic       clk = 1'b0;
    int         errors = 0;
    int         checks = 0;

    logic       rst_a, rst_b;
    logic [3:0] ack_a, ack_b;
    logic [3:0] out_a, out_b;
    logic [1:0] idx_a, idx_b;
    logic       done_a, done_b, fault_a, fault_b;

    always #5 clk = ~clk;

    reset_sequencer dut_a (
        .clk(clk), .reset(rst_a), .ack(ack_a), .rst_out(out_a),
        .stage_idx(idx_a), .done(done_a), .fault(fault_a)
    );

    reset_sequencer #(.num_stages(4), .hold_cycles(1), .gap_cycles(0)) dut_b (
        .clk(clk), .reset(rst_b), .ack(ack_b), .rst_out(out_b),
        .stage_idx(idx_b), .done(done_b), .fault(fault_b)
    );

`ifdef RESET_SEQUENCER_TIMEOUT_EN
    logic       rst_t;
    logic [3:0] ack_t, out_t;
    logic [1:0] idx_t;
    logic       done_t, fault_t;

    reset_sequencer #(.num_stages(4), .hold_cycles(16), .gap_cycles(8), .timeout_cycles(20)) dut_t (
        .clk(clk), .reset(rst_t), .ack(ack_t), .rst_out(out_t),
        .stage_idx(idx_t), .done(done_t), .fault(fault_t)
    );
`endif

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Assumes dut_a reset was just released with all acks high; edges counted from release.
    task automatic seq_defaults(input string tag);
        step(16);
        chk({tag, " e16 rst_out"}, 32'(out_a), 32'hF);
        step(1);
        chk({tag, " e17 rst_out"}, 32'(out_a), 32'hE);
        chk({tag, " e17 idx"}, 32'(idx_a), 32'd0);
        step(1);
        chk({tag, " e18 idx"}, 32'(idx_a), 32'd1);
        step(8);
        chk({tag, " e26 rst_out"}, 32'(out_a), 32'hE);
        step(1);
        chk({tag, " e27 rst_out"}, 32'(out_a), 32'hC);
        step(10);
        chk({tag, " e37 rst_out"}, 32'(out_a), 32'h8);
        step(10);
        chk({tag, " e47 rst_out"}, 32'(out_a), 32'h0);
        chk({tag, " e47 done"}, 32'(done_a), 32'd0);
        step(1);
        chk({tag, " e48 done"}, 32'(done_a), 32'd1);
        chk({tag, " e48 idx"}, 32'(idx_a), 32'd3);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_a = 1'b1; ack_a = 4'hF;
        rst_b = 1'b1; ack_b = 4'hF;
`ifdef RESET_SEQUENCER_TIMEOUT_EN
        rst_t = 1'b1; ack_t = 4'h0;
`endif

        // Test 1: defaults, acks high
        step(5);
        chk("t1 reset rst_out", 32'(out_a), 32'hF);
        chk("t1 reset done", 32'(done_a), 32'd0);
        chk("t1 reset idx", 32'(idx_a), 32'd0);
        chk("t1 reset fault", 32'(fault_a), 32'd0);
        rst_a = 1'b0;
        seq_defaults("t1");
        ack_a = 4'h0;
        step(20);
        chk("t1 done hold", 32'(done_a), 32'd1);
        chk("t1 done rst_out", 32'(out_a), 32'h0);

        // Test 2: ack[1] late, later acks early
        rst_a = 1'b1; ack_a = 4'b1101;
        step(1);
        chk("t2 reset from done rst_out", 32'(out_a), 32'hF);
        chk("t2 reset from done done", 32'(done_a), 32'd0);
        rst_a = 1'b0;
        step(27);
        chk("t2 e27 rst_out", 32'(out_a), 32'hC);
        step(30);
        chk("t2 e57 rst_out", 32'(out_a), 32'hC);
        chk("t2 e57 idx", 32'(idx_a), 32'd1);
        chk("t2 e57 fault", 32'(fault_a), 32'd0);
        step(20);
        chk("t2 e77 rst_out", 32'(out_a), 32'hC);
        ack_a = 4'hF;
        step(1);
        chk("t2 e78 idx", 32'(idx_a), 32'd2);
        step(8);
        chk("t2 e86 rst_out", 32'(out_a), 32'hC);
        step(1);
        chk("t2 e87 rst_out", 32'(out_a), 32'h8);
        step(10);
        chk("t2 e97 rst_out", 32'(out_a), 32'h0);
        step(1);
        chk("t2 e98 done", 32'(done_a), 32'd1);

        // Test 3: hold=1, gap=0
        step(1);
        chk("t3 reset rst_out", 32'(out_b), 32'hF);
        rst_b = 1'b0;
        step(1);
        chk("t3 e1 rst_out", 32'(out_b), 32'hF);
        step(1);
        chk("t3 e2 rst_out", 32'(out_b), 32'hE);
        step(1);
        chk("t3 e3 idx", 32'(idx_b), 32'd1);
        step(1);
        chk("t3 e4 rst_out", 32'(out_b), 32'hC);
        step(2);
        chk("t3 e6 rst_out", 32'(out_b), 32'h8);
        step(2);
        chk("t3 e8 rst_out", 32'(out_b), 32'h0);
        chk("t3 e8 done", 32'(done_b), 32'd0);
        step(1);
        chk("t3 e9 done", 32'(done_b), 32'd1);

        // Test 4: reset pulse while waiting on stage 2
        rst_a = 1'b1; ack_a = 4'hF;
        step(2);
        rst_a = 1'b0;
        step(37);
        chk("t4 e37 rst_out", 32'(out_a), 32'h8);
        chk("t4 e37 idx", 32'(idx_a), 32'd2);
        rst_a = 1'b1;
        step(1);
        chk("t4 pulse rst_out", 32'(out_a), 32'hF);
        chk("t4 pulse done", 32'(done_a), 32'd0);
        chk("t4 pulse idx", 32'(idx_a), 32'd0);
        rst_a = 1'b0;
        seq_defaults("t4");

`ifdef RESET_SEQUENCER_TIMEOUT_EN
        // Test 5: ack[1] never arrives
        ack_t = 4'b1101;
        step(3);
        rst_t = 1'b0;
        step(27);
        chk("t5 e27 rst_out", 32'(out_t), 32'hC);
        step(19);
        chk("t5 e46 fault", 32'(fault_t), 32'd0);
        chk("t5 e46 rst_out", 32'(out_t), 32'hC);
        step(1);
        chk("t5 e47 fault", 32'(fault_t), 32'd1);
        chk("t5 e47 rst_out", 32'(out_t), 32'hF);
        chk("t5 e47 idx", 32'(idx_t), 32'd1);
        chk("t5 e47 done", 32'(done_t), 32'd0);
        ack_t = 4'hF;
        step(100);
        chk("t5 sticky fault", 32'(fault_t), 32'd1);
        chk("t5 sticky rst_out", 32'(out_t), 32'hF);
        chk("t5 sticky idx", 32'(idx_t), 32'd1);
        rst_t = 1'b1;
        step(1);
        chk("t5 reset fault", 32'(fault_t), 32'd0);
        chk("t5 reset idx", 32'(idx_t), 32'd0);

        // Test 6: ack[0] on the last allowed wait cycle
        ack_t = 4'h0;
        step(1);
        rst_t = 1'b0;
        step(36);
        chk("t6 e36 fault", 32'(fault_t), 32'd0);
        chk("t6 e36 idx", 32'(idx_t), 32'd0);
        ack_t = 4'h1;
        step(1);
        chk("t6 e37 fault", 32'(fault_t), 32'd0);
        chk("t6 e37 idx", 32'(idx_t), 32'd1);
        ack_t = 4'hF;
        step(30);
        chk("t6 e67 rst_out", 32'(out_t), 32'h0);
        step(1);
        chk("t6 e68 done", 32'(done_t), 32'd1);
        chk("t6 e68 fault", 32'(fault_t), 32'd0);
`else
        chk("fault tied low a", 32'(fault_a), 32'd0);
        chk("fault tied low b", 32'(fault_b), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
